sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Shares the single 256Kx16 board SRAM between three requesters: video scan-out,
//  CPU bus and JTAG loader. Sequences every SRAM access (address/OE/WE/UB/LB/DQ
//  timing) from clk50 and returns read data with a one-cycle ack. Sits between the
//  bk0010 core and the SRAM pins of the DE1 top level.
// PARAMETERS
//  WAIT_CYCLES  2  clk50 cycles the SRAM strobe (OE or WE) is held per access, range 1..7
// PORTS
//  clk50       in   1   system clock, all logic on rising edge
//  reset_in    in   1   asynchronous, active-high reset
//  vid_req     in   1   video read request, level, held until vid_ack
//  vid_addr    in   18  video word address
//  vid_ack     out  1   1-cycle pulse: rdata valid for video
//  cpu_req     in   1   CPU request, level, held until cpu_ack
//  cpu_we      in   1   1=write 0=read
//  cpu_be      in   2   byte enables {ub,lb}; reads ignore, forced 2'b11
//  cpu_addr    in   18  CPU word address
//  cpu_wdata   in   16  CPU write data
//  cpu_ack     out  1   1-cycle pulse: access complete (rdata valid on read)
//  ldr_req/ldr_we/ldr_be/ldr_addr/ldr_wdata/ldr_ack  same as cpu_*, JTAG loader port
//  rdata       out  16  read data, shared by all requesters, held until next read
//  sram_addr   out  18  SRAM address
//  sram_dq     inout 16 SRAM data; driven only during write states
//  sram_ce_n/sram_oe_n/sram_we_n/sram_ub_n/sram_lb_n  out 1 each, SRAM strobes
// BEHAVIOUR
//  - Reset (async): state IDLE, all acks 0, rdata 0, sram_addr 0, ce_n/oe_n/we_n/
//    ub_n/lb_n = 1, sram_dq high-Z, round-robin pointer = CPU. Reset mid-access aborts
//    it immediately; no ack is issued for the aborted access.
//  - All SRAM outputs and acks are registered; no combinational path req->pins.
//  - States: IDLE, READ, WRITE, TURN.
//  - IDLE: arbitrate on current requests. vid_req wins unconditionally; else between
//    cpu and ldr round-robin: pointer names the preferred one, pointer flips to the
//    other after each granted cpu/ldr access. Winner's addr/be/wdata/we latched,
//    ce_n=0, next state READ or WRITE. No request: stay IDLE, ce_n=1.
//  - READ: oe_n=0, ub_n=lb_n=0, for WAIT_CYCLES cycles; on last cycle rdata<=sram_dq,
//    winner's ack=1 for exactly that one following cycle, go IDLE.
//  - WRITE: dq driven with wdata, ub_n/lb_n = ~be, we_n=0 for WAIT_CYCLES cycles, then
//    TURN. be=2'b00 write still runs the full sequence with we_n pulsed, no bytes
//    written, ack still issued.
//  - TURN: 1 cycle, we_n=1, dq still driven (data hold), ack pulse, then IDLE with dq
//    released.
//  - Latency, req seen in IDLE at edge N: read ack high after edge N+WAIT_CYCLES+1;
//    write ack high after edge N+WAIT_CYCLES+2. Minimum 1 IDLE cycle between accesses.
//  - Requester must deassert req on the cycle after ack or it is re-granted; a req
//    dropped before ack is protocol error, access still completes and acks.
//  - Requests changing addr/data while waiting have no effect after latch in IDLE.
//  - ce_n low from grant through the last READ/TURN cycle; high in IDLE.
//  - Only one ack high in any cycle; rdata only updated by reads.
// TESTING
//  - Reset mid-WRITE (reset_in pulsed during we_n=0) -> we_n=1, dq Z same cycle, no ack.
//  - CPU write 0x1234 @0x00010 be=2'b11, then read -> cpu_ack twice, rdata=0x1234,
//    write ack at N+4, read ack at N+3 with WAIT_CYCLES=2.
//  - Byte write be=2'b10 data 0xAB00 over 0x1234 -> ub_n=0 lb_n=1 during WRITE;
//    readback 0xAB34.
//  - vid_req, cpu_req, ldr_req all high in same cycle -> order video, cpu, video, ldr
//    (video held continuously wins each IDLE; cpu/ldr alternate when video drops).
//  - cpu_req and ldr_req held continuously for 10 accesses -> grants alternate
//    cpu,ldr,cpu,... 5 each, no two acks ever coincident.
//  - Model SRAM with random data, 1000 random mixed accesses across all ports ->
//    every rdata matches model, dq never driven while oe_n=0.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - three-port (video/cpu/loader) arbiter and access sequencer for a 256Kx16 async SRAM
// Video has fixed priority; cpu and loader share a round-robin pointer. All pins and acks are registered.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk50,
    input  logic        reset_in,
    input  logic        vid_req,
    input  logic [17:0] vid_addr,
    output logic        vid_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_be,
    input  logic [17:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [1:0]  ldr_be,
    input  logic [17:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic        ldr_ack,
    output logic [15:0] rdata,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;
    typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_LDR} owner_t;

    localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

    state_t      state, state_nxt;
    owner_t      owner, owner_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        rr_ldr, rr_ldr_nxt;
    logic [17:0] addr_q, addr_nxt;
    logic [15:0] dq_out, dq_out_nxt;
    logic        dq_oe, dq_oe_nxt;
    logic [15:0] rdata_q, rdata_nxt;
    logic        ce_n, ce_n_nxt, oe_n, oe_n_nxt, we_n, we_n_nxt;
    logic        ub_n, ub_n_nxt, lb_n, lb_n_nxt;
    logic [2:0]  ack, ack_nxt;

    logic        grant_cpu, grant_ldr, sel_we;
    logic [1:0]  sel_be;
    logic [17:0] sel_addr;
    logic [15:0] sel_wdata;

    // rr_ldr set means the loader is preferred when both cpu and loader are pending
    assign grant_cpu = cpu_req && !vid_req && (!rr_ldr || !ldr_req);
    assign grant_ldr = ldr_req && !vid_req && !grant_cpu;
    assign sel_we    = grant_ldr ? ldr_we    : cpu_we;
    assign sel_be    = grant_ldr ? ldr_be    : cpu_be;
    assign sel_addr  = grant_ldr ? ldr_addr  : cpu_addr;
    assign sel_wdata = grant_ldr ? ldr_wdata : cpu_wdata;

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        cnt_nxt    = cnt;
        rr_ldr_nxt = rr_ldr;
        addr_nxt   = addr_q;
        dq_out_nxt = dq_out;
        dq_oe_nxt  = dq_oe;
        rdata_nxt  = rdata_q;
        ce_n_nxt   = ce_n;
        oe_n_nxt   = oe_n;
        we_n_nxt   = we_n;
        ub_n_nxt   = ub_n;
        lb_n_nxt   = lb_n;
        ack_nxt    = 3'b000;

        unique case (state)
            IDLE: begin
                if (vid_req) begin
                    owner_nxt = OWN_VID;
                    addr_nxt  = vid_addr;
                    ce_n_nxt  = 1'b0;
                    ub_n_nxt  = 1'b0;
                    lb_n_nxt  = 1'b0;
                    cnt_nxt   = 3'd0;
                    state_nxt = READ;
                end else if (grant_cpu || grant_ldr) begin
                    owner_nxt  = grant_ldr ? OWN_LDR : OWN_CPU;
                    rr_ldr_nxt = grant_cpu;
                    addr_nxt   = sel_addr;
                    ce_n_nxt   = 1'b0;
                    cnt_nxt    = 3'd0;
                    if (sel_we) begin
                        dq_out_nxt = sel_wdata;
                        dq_oe_nxt  = 1'b1;
                        ub_n_nxt   = ~sel_be[1];
                        lb_n_nxt   = ~sel_be[0];
                        state_nxt  = WRITE;
                    end else begin
                        ub_n_nxt  = 1'b0;
                        lb_n_nxt  = 1'b0;
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                if (cnt == LAST) begin
                    rdata_nxt        = sram_dq;
                    ack_nxt[owner]   = 1'b1;
                    oe_n_nxt         = 1'b1;
                    ce_n_nxt         = 1'b1;
                    ub_n_nxt         = 1'b1;
                    lb_n_nxt         = 1'b1;
                    state_nxt        = IDLE;
                end else begin
                    oe_n_nxt = 1'b0;
                    cnt_nxt  = cnt + 3'd1;
                end
            end
            WRITE: begin
                if (cnt == LAST) begin
                    we_n_nxt  = 1'b1;
                    state_nxt = TURN;
                end else begin
                    we_n_nxt = 1'b0;
                    cnt_nxt  = cnt + 3'd1;
                end
            end
            TURN: begin
                // data held one cycle past the we_n rising edge
                ack_nxt[owner] = 1'b1;
                dq_oe_nxt      = 1'b0;
                ce_n_nxt       = 1'b1;
                ub_n_nxt       = 1'b1;
                lb_n_nxt       = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset_in) begin
        if (reset_in) begin
            state   <= IDLE;
            owner   <= OWN_CPU;
            cnt     <= 3'd0;
            rr_ldr  <= 1'b0;
            addr_q  <= 18'd0;
            dq_out  <= 16'd0;
            dq_oe   <= 1'b0;
            rdata_q <= 16'd0;
            ce_n    <= 1'b1;
            oe_n    <= 1'b1;
            we_n    <= 1'b1;
            ub_n    <= 1'b1;
            lb_n    <= 1'b1;
            ack     <= 3'b000;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            cnt     <= cnt_nxt;
            rr_ldr  <= rr_ldr_nxt;
            addr_q  <= addr_nxt;
            dq_out  <= dq_out_nxt;
            dq_oe   <= dq_oe_nxt;
            rdata_q <= rdata_nxt;
            ce_n    <= ce_n_nxt;
            oe_n    <= oe_n_nxt;
            we_n    <= we_n_nxt;
            ub_n    <= ub_n_nxt;
            lb_n    <= lb_n_nxt;
            ack     <= ack_nxt;
        end
    end

    assign sram_dq   = dq_oe ? dq_out : 16'hzzzz;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n;
    assign sram_oe_n = oe_n;
    assign sram_we_n = we_n;
    assign sram_ub_n = ub_n;
    assign sram_lb_n = lb_n;
    assign rdata     = rdata_q;
    assign vid_ack   = ack[0];
    assign cpu_ack   = ack[1];
    assign ldr_ack   = ack[2];
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with a behavioural SRAM and memory model
module tb_sram_arbiter;
    localparam int W = 2;

    logic        clk50 = 1'b0;
    logic        reset_in;
    logic        vid_req, cpu_req, ldr_req, cpu_we, ldr_we;
    logic [17:0] vid_addr, cpu_addr, ldr_addr;
    logic [1:0]  cpu_be, ldr_be;
    logic [15:0] cpu_wdata, ldr_wdata;
    logic        vid_ack, cpu_ack, ldr_ack;
    logic [15:0] rdata;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int checks, errors;
    logic [15:0] sram_mem [0:262143];
    logic [15:0] ref_mem  [0:262143];
    int ack_log [$];
    int ack_multi = 0, strobe_clash = 0, we_cycles = 0;
    logic we_ub = 1'b1, we_lb = 1'b1;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk50(clk50), .reset_in(reset_in),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .rdata(rdata), .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #10 clk50 = ~clk50;

    // asynchronous SRAM: drives dq while selected and output-enabled, latches bytes while we_n low
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;
    initial begin
        for (int a = 0; a < 262144; a++) sram_mem[a] = 16'($urandom);
        forever begin
            @(posedge clk50);
            if (!sram_ce_n && !sram_we_n) begin
                if (!sram_ub_n) sram_mem[sram_addr][15:8] = sram_dq[15:8];
                if (!sram_lb_n) sram_mem[sram_addr][7:0]  = sram_dq[7:0];
            end
        end
    end

    always @(negedge clk50) begin
        if (!reset_in) begin
            if (32'(vid_ack) + 32'(cpu_ack) + 32'(ldr_ack) > 1) ack_multi++;
            if (vid_ack) ack_log.push_back(0);
            if (cpu_ack) ack_log.push_back(1);
            if (ldr_ack) ack_log.push_back(2);
            if (!sram_oe_n && !sram_we_n) strobe_clash++;
            if (!sram_we_n) begin
                we_cycles++;
                we_ub = sram_ub_n;
                we_lb = sram_lb_n;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic port_access(input int p, input logic we, input logic [1:0] be,
                               input logic [17:0] addr, input logic [15:0] wd,
                               output int lat, output logic [15:0] rd, output bit ok);
        case (p)
            0: begin vid_addr = addr; vid_req = 1'b1; end
            1: begin cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1; end
            default: begin ldr_we = we; ldr_be = be; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1; end
        endcase
        ok = 1'b0; lat = 0;
        while (!ok && lat < 200) begin
            @(posedge clk50); #1;
            lat++;
            ok = (p == 0) ? vid_ack : (p == 1) ? cpu_ack : ldr_ack;
        end
        rd = rdata;
        case (p)
            0: vid_req = 1'b0;
            1: cpu_req = 1'b0;
            default: ldr_req = 1'b0;
        endcase
        if (ok && we && p != 0) begin
            if (be[1]) ref_mem[addr][15:8] = wd[15:8];
            if (be[0]) ref_mem[addr][7:0]  = wd[7:0];
        end
        @(posedge clk50); #1;
    endtask

    task automatic do_reset();
        vid_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        reset_in = 1'b1;
        repeat (2) @(posedge clk50);
        #1 reset_in = 1'b0;
        @(posedge clk50); #1;
    endtask

    task automatic test_reset();
        logic [40:0] got;
        do_reset();
        reset_in = 1'b1;
        #1;
        got = {vid_ack, cpu_ack, ldr_ack, rdata, sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n};
        checks++;
        if (got !== {3'b000, 16'h0000, 18'h00000, 5'b11111}) begin
            errors++; $display("FAIL reset_state got %h want %h", got, {3'b000, 16'h0000, 18'h00000, 5'b11111});
        end
        #1 reset_in = 1'b0;
        repeat (3) @(posedge clk50);
        #1;
        checks++;
        if ({sram_ce_n, vid_ack, cpu_ack, ldr_ack} !== 4'b1000) begin
            errors++; $display("FAIL idle_no_req got %b want 1000", {sram_ce_n, vid_ack, cpu_ack, ldr_ack});
        end
    endtask

    task automatic test_rw();
        int lat, wc; logic [15:0] rd; bit ok;
        port_access(1, 1'b1, 2'b11, 18'h00010, 16'h1234, lat, rd, ok);
        checks++;
        if (!ok || lat != W + 3) begin errors++; $display("FAIL cpu_write_latency got %0d want %0d", lat, W + 3); end
        port_access(1, 1'b0, 2'b11, 18'h00010, 16'h0000, lat, rd, ok);
        checks++;
        if (!ok || lat != W + 2) begin errors++; $display("FAIL cpu_read_latency got %0d want %0d", lat, W + 2); end
        checks++;
        if (rd !== 16'h1234) begin errors++; $display("FAIL cpu_readback got %h want 1234", rd); end
        wc = we_cycles;
        port_access(1, 1'b1, 2'b10, 18'h00010, 16'hAB00, lat, rd, ok);
        checks++;
        if ({we_ub, we_lb} !== 2'b01) begin errors++; $display("FAIL byte_strobes got %b want 01", {we_ub, we_lb}); end
        checks++;
        if (we_cycles - wc != W) begin errors++; $display("FAIL we_width got %0d want %0d", we_cycles - wc, W); end
        checks++;
        if (rdata !== 16'h1234) begin errors++; $display("FAIL rdata_after_write got %h want 1234", rdata); end
        port_access(2, 1'b0, 2'b00, 18'h00010, 16'h0000, lat, rd, ok);
        checks++;
        if (!ok || rd !== 16'hAB34) begin errors++; $display("FAIL byte_readback got %h want ab34", rd); end
        wc = we_cycles;
        port_access(2, 1'b1, 2'b00, 18'h00010, 16'hFFFF, lat, rd, ok);
        checks++;
        if (!ok || lat != W + 3 || we_cycles - wc != W) begin
            errors++; $display("FAIL be00_write got lat %0d we %0d want %0d %0d", lat, we_cycles - wc, W + 3, W);
        end
        port_access(0, 1'b0, 2'b00, 18'h00010, 16'h0000, lat, rd, ok);
        checks++;
        if (!ok || lat != W + 2 || rd !== 16'hAB34) begin
            errors++; $display("FAIL video_read got lat %0d data %h want %0d ab34", lat, rd, W + 2);
        end
    endtask

    task automatic test_arb_order();
        int base; int lat0, lat1, lat2, lat3; logic [15:0] r0, r1, r2, r3; bit k0, k1, k2, k3;
        do_reset();
        base = ack_log.size();
        fork
            begin
                port_access(0, 1'b0, 2'b00, 18'h00020, 16'h0, lat0, r0, k0);
                port_access(0, 1'b0, 2'b00, 18'h00021, 16'h0, lat1, r1, k1);
            end
            port_access(1, 1'b0, 2'b11, 18'h00022, 16'h0, lat2, r2, k2);
            port_access(2, 1'b0, 2'b11, 18'h00023, 16'h0, lat3, r3, k3);
        join
        checks++;
        if (ack_log.size() - base != 4 || ack_log[base] != 0 || ack_log[base + 1] != 1 ||
            ack_log[base + 2] != 0 || ack_log[base + 3] != 2) begin
            errors++;
            $display("FAIL arb_order got %0d acks first %0d %0d want 0 1 0 2", ack_log.size() - base,
                     ack_log[base], ack_log[base + 1]);
        end
    endtask

    task automatic test_alternate();
        int base, n, cyc, m0; bit order_ok;
        do_reset();
        base = ack_log.size(); m0 = ack_multi;
        cpu_we = 1'b0; ldr_we = 1'b0; cpu_addr = 18'h00030; ldr_addr = 18'h00031;
        cpu_req = 1'b1; ldr_req = 1'b1;
        n = 0; cyc = 0;
        while (n < 10 && cyc < 300) begin
            @(posedge clk50); #1;
            cyc++;
            n += 32'(cpu_ack) + 32'(ldr_ack);
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (8) @(posedge clk50);
        #1;
        order_ok = (ack_log.size() - base == 10);
        for (int i = 0; i < 10 && order_ok; i++) order_ok = (ack_log[base + i] == 1 + (i % 2));
        checks++;
        if (!order_ok) begin errors++; $display("FAIL alternate got %0d acks want 10 alternating cpu/ldr", ack_log.size() - base); end
        checks++;
        if (ack_multi != m0) begin errors++; $display("FAIL ack_overlap got %0d want 0", ack_multi - m0); end
    endtask

    task automatic test_random();
        fork
            for (int p = 0; p < 3; p++) begin
                automatic int pp = p;
                fork
                    for (int i = 0; i < 334; i++) begin
                        int lat; logic [15:0] rd; bit ok; logic we; logic [17:0] a;
                        logic [1:0] be; logic [15:0] wd;
                        we = (pp != 0) && ($urandom_range(0, 1) == 1);
                        be = 2'($urandom);
                        wd = 16'($urandom);
                        a  = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(0, 31));
                        port_access(pp, we, be, a, wd, lat, rd, ok);
                        checks++;
                        if (!ok) begin errors++; $display("FAIL rand_timeout port %0d got no ack want ack", pp); end
                        else if (!we && rd !== ref_mem[a]) begin
                            errors++; $display("FAIL rand_read port %0d addr %h got %h want %h", pp, a, rd, ref_mem[a]);
                        end
                        repeat ($urandom_range(0, 2)) @(posedge clk50);
                        #1;
                    end
                join_none
            end
        join_none
        wait fork;
        checks++;
        if (strobe_clash != 0) begin errors++; $display("FAIL oe_we_overlap got %0d want 0", strobe_clash); end
        checks++;
        if (ack_multi != 0) begin errors++; $display("FAIL ack_multi got %0d want 0", ack_multi); end
    endtask

    task automatic test_reset_mid_write();
        bit found; int acks; logic [20:0] got;
        cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 18'h3F000; cpu_wdata = 16'h5555; cpu_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk50); #1;
            found = !sram_we_n;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_write_start got no we_n low want we_n low"); end
        #3 reset_in = 1'b1;
        #1;
        got = {sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n, rdata};
        checks++;
        if (got !== {5'b11111, 16'h0000}) begin errors++; $display("FAIL mid_write_reset got %h want %h", got, {5'b11111, 16'h0000}); end
        cpu_req = 1'b0;
        @(posedge clk50); #1 reset_in = 1'b0;
        acks = 0;
        repeat (10) begin @(posedge clk50); #1; acks += 32'(cpu_ack); end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL aborted_ack got %0d want 0", acks); end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_in = 1'b1;
        vid_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        vid_addr = '0; cpu_addr = '0; ldr_addr = '0;
        cpu_we = 1'b0; ldr_we = 1'b0; cpu_be = 2'b11; ldr_be = 2'b11;
        cpu_wdata = '0; ldr_wdata = '0;
        test_reset();
        for (int a = 0; a < 262144; a++) ref_mem[a] = sram_mem[a];
        test_rw();
        test_arb_order();
        test_alternate();
        test_random();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
